// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - default sizes, register typedefs and address helper for the register file
package rf_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

  // Register 0 is hardwired zero and indices past the file are ignored.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned nregs);
    return (addr != 0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write flags and running count of busy registers
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_count
);

  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic set_ok;
  logic clr_ok;
  logic set_new;
  logic clr_eff;

  // Count moves only on real 0->1 / 1->0 transitions; an issue to the register
  // being written in the same cycle keeps it busy, so that clear never lands.
  always_comb begin
    set_ok  = issue_valid && addr_ok(32'(issue_rd), NREGS);
    clr_ok  = we && addr_ok(32'(wr_addr), NREGS);
    set_new = set_ok && !busy[issue_rd];
    clr_eff = clr_ok && busy[wr_addr] && !(set_ok && (issue_rd == wr_addr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (clr_ok) busy[wr_addr] <= 1'b0;
      if (set_ok) busy[issue_rd] <= 1'b1;
      case ({set_new, clr_eff})
        2'b10:   busy_count <= busy_count + ONE;
        2'b01:   busy_count <= busy_count - ONE;
        default: busy_count <= busy_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write forwarding and issue scoreboard
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;
  logic [AW-1:0]    ra;
  logic             fwd;

  assign wr_ok = we && addr_ok(32'(wr_addr), NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A forwarded write also hides the busy flag: the consumer already has the value.
  always_comb begin
    rd_data = '0;
    rs_busy = '0;
    ra      = '0;
    fwd     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rs_addr[i*AW +: AW];
      fwd = (BYPASS != 0) && wr_ok && (wr_addr == ra);
      if (addr_ok(32'(ra), NREGS)) begin
        rd_data[i*XLEN +: XLEN] = fwd ? wr_data : regs[ra];
        rs_busy[i]              = busy[ra] && !fwd;
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we          (we),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .busy_count  (busy_count)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL expose parameter XLEN, default 64, register data width in bits.
REQ-002 The block SHALL expose parameter NREGS, default 32, architectural register count; AW = clog2(NREGS), derived.
REQ-003 The block SHALL expose parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL expose parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; ports are clk and reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 rs_addr  input  NRD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-009 rd_data  output  NRD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN].
REQ-010 rs_busy  output  NRD  per-port flag: source register has a pending, unforwarded write.
REQ-011 we  input  1  write enable (writeback).
REQ-012 wr_addr  input  AW  write address.
REQ-013 wr_data  input  XLEN  write data.
REQ-014 issue_valid  input  1  instruction issue; marks issue_rd as pending.
REQ-015 issue_rd  input  AW  destination register of the issuing instruction.
REQ-016 busy_count  output  AW+1  number of registers currently marked busy.

Function
REQ-017 Write SHALL commit at the rising clk edge when we=1, wr_addr!=0 and wr_addr<NREGS; otherwise no register changes.
REQ-018 Reads SHALL be combinational; rd_data port i = register[rs_addr[i]].
REQ-019 Address 0 SHALL read as zero on every port, regardless of we/wr_data, and SHALL never be busy.
REQ-020 Addresses >= NREGS SHALL read zero, ignore writes and issues, and never be busy.
REQ-021 BYPASS=1: when we=1 and wr_addr==rs_addr[i]!=0, port i SHALL return wr_data in the same cycle; BYPASS=0: port i SHALL return the stored (old) value until the edge.
REQ-022 Scoreboard: issue_valid=1 with valid nonzero issue_rd SHALL set busy[issue_rd] at the next edge.
REQ-023 we=1 with valid nonzero wr_addr SHALL clear busy[wr_addr] at the next edge.
REQ-024 Issue and write to the same register in one cycle: set SHALL win (register busy after the edge).
REQ-025 Issue to an already busy register SHALL leave it busy; write to a non-busy register SHALL still update data.
REQ-026 rs_busy[i] SHALL equal busy[rs_addr[i]], masked to 0 when BYPASS=1, we=1 and wr_addr==rs_addr[i].
REQ-027 busy_count SHALL equal popcount(busy) after every edge, maintained incrementally (+1, -1 or 0 per cycle); simultaneous set of one register and clear of another SHALL leave it unchanged.
REQ-028 busy_count SHALL never exceed NREGS-1 nor underflow below 0.

Reset
REQ-029 When reset=1 at an edge, all registers SHALL become 0, all busy bits 0 and busy_count 0.
REQ-030 Reset SHALL dominate we and issue_valid in the same cycle; neither has any effect.
REQ-031 After reset, every rd_data port SHALL read 0 and rs_busy SHALL be all 0 (unless bypass of a concurrent write applies).
REQ-032 Reset asserted mid-operation SHALL discard all pending busy marks; a later writeback to a formerly busy register SHALL write data and leave busy_count at 0.

Structure
REQ-033 Package rf_pkg SHALL hold default XLEN, NREGS, NRD constants and the register-address and data typedefs.
REQ-034 The busy vector and busy_count SHALL live in one sub-module, rf_scoreboard; storage and read muxes stay in reg_file_sb.

Verification
REQ-035 Reset, then we=1, wr_addr=9, wr_data=100 for one edge, rs_addr[0]=9 -> rd_data[0]=100 after the edge; rs_addr[1]=0 -> 0.
REQ-036 BYPASS=1: reg 9 holds 100, drive we=1, wr_addr=9, wr_data=250 -> rd_data[0]=250 before the edge; BYPASS=0 -> 100 before, 250 after.
REQ-037 we=1, wr_addr=0, wr_data=100 -> rs_addr[0]=0 reads 0 before and after the edge; busy_count unchanged.
REQ-038 issue_valid with issue_rd=5 then 7 -> busy_count 1 then 2, rs_busy set for 5; same cycle issue_rd=5 and we wr_addr=5 -> reg 5 stays busy, count 2; we wr_addr=7 -> count 1.
REQ-039 Registers 9=250, 5 busy; pulse reset one cycle -> all reads 0, busy_count 0; then we wr_addr=5, wr_data=3 -> reads 3, count stays 0.
REQ-040 Reset and we (wr_addr=9, wr_data=100) in the same cycle -> reg 9 reads 0 after the edge.
